// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer and PC for the MIPS core.
// The instruction and data buses use a req/ack handshake, so memories can insert wait states.
// A request that goes ACK_TIMEOUT cycles without an ack halts the core and sets bus_error.
// Optional feature macro: MIPS_SEQ_PERF_CNT_EN adds the cycle and retired-instruction counters.
module mips_multicycle_sequencer #(
    parameter int unsigned                ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = '0,
    parameter int unsigned                ACK_TIMEOUT  = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  instr_req,
    input  logic                  instr_ack,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic [31:0]           instr_rdata,
    output logic [31:0]           ir,
    output logic                  data_req,
    output logic                  data_we,
    input  logic                  data_ack,
    input  logic                  alu_zero,
    input  logic [ADDR_WIDTH-1:0] jr_target,
    output logic                  reg_write,
    output logic [1:0]            mem_to_reg,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  halted,
    output logic                  bus_error
`ifdef MIPS_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           retired_count
`endif
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [ADDR_WIDTH-1:0] JMASK = ADDR_WIDTH'({28{1'b1}});

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   pc_d;
    logic                    ir_load;
    logic                    set_err;
    logic                    timeout_hit;
    logic [CNT_W-1:0]        wait_cnt;
    logic [5:0]              opcode;
    logic [5:0]              funct;
    logic [27:0]             jump_low;
    logic [31:0]             br_off;
    logic [ADDR_WIDTH-1:0]   jump_target;
    logic [ADDR_WIDTH-1:0]   br_target;

    // Instruction fields and candidate PC targets
    assign opcode      = ir[31:26];
    assign funct       = ir[5:0];
    assign pc_plus4    = pc + ADDR_WIDTH'(4);
    assign instr_addr  = pc;
    assign halted      = (state == S_HALT);
    assign jump_low    = {ir[25:0], 2'b00};
    assign jump_target = (pc_plus4 & ~JMASK) | (ADDR_WIDTH'(jump_low) & JMASK);
    assign br_off      = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign br_target   = pc_plus4 + ADDR_WIDTH'($signed(br_off));
    assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // Next-state, PC update and strobe decode from registered state and ir
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        ir_load    = 1'b0;
        set_err    = 1'b0;
        instr_req  = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        case (state)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    set_err = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    pc_d    = jump_target;
                    state_d = S_FETCH;
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        mem_to_reg = 2'b10;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opcode == OP_RTYPE && funct == FN_JR) begin
                    pc_d    = jr_target;
                    state_d = S_FETCH;
                end else if (opcode == OP_BEQ) begin
                    pc_d    = alu_zero ? br_target : pc_plus4;
                    state_d = S_FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM;
                end else if (opcode == OP_RTYPE || opcode == OP_ADDI) begin
                    state_d = S_WB;
                end else begin
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                data_req = 1'b1;
                data_we  = (opcode == OP_SW);
                if (data_ack) begin
                    if (opcode == OP_SW) begin
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    set_err = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LW) ? 2'b01 : 2'b00;
                pc_d       = pc_plus4;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
        // Requests and strobes drop as soon as reset is asserted
        if (reset) begin
            instr_req  = 1'b0;
            data_req   = 1'b0;
            data_we    = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 2'b00;
        end
    end

    // State, PC, instruction register and sticky bus error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_VECTOR;
            ir        <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (ir_load) begin
                ir <= instr_rdata;
            end
            if (set_err) begin
                bus_error <= 1'b1;
            end
        end
    end

    // Per-request wait counter, cleared whenever the state changes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_d != state) begin
            wait_cnt <= '0;
        end else if (ACK_TIMEOUT != 0 && (state == S_FETCH || state == S_MEM)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

`ifdef MIPS_SEQ_PERF_CNT_EN
    // Cycle and retirement counters, frozen once halted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else if (state != S_HALT) begin
            cycle_count <= cycle_count + 32'd1;
            if (state_d == S_FETCH && state != S_FETCH) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Directed bench for mips_multicycle_sequencer (RESET_VECTOR=0x100, ACK_TIMEOUT=15).
module tb_mips_multicycle_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req;
    logic        instr_ack = 1'b0;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata = '0;
    logic [31:0] ir;
    logic        data_req;
    logic        data_we;
    logic        data_ack = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] jr_target = '0;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        bus_error;
`ifdef MIPS_SEQ_PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
`endif

    int checks = 0;
    int errors = 0;

    mips_multicycle_sequencer #(
        .ADDR_WIDTH   (32),
        .RESET_VECTOR (32'h100),
        .ACK_TIMEOUT  (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_req   (instr_req),
        .instr_ack   (instr_ack),
        .instr_addr  (instr_addr),
        .instr_rdata (instr_rdata),
        .ir          (ir),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_ack    (data_ack),
        .alu_zero    (alu_zero),
        .jr_target   (jr_target),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .bus_error   (bus_error)
`ifdef MIPS_SEQ_PERF_CNT_EN
        ,
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
`endif
    );

    always #5 clock = ~clock;

    // Advance one clock; sampling point sits just after the falling edge
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Present one instruction word for a single zero-wait fetch cycle
    task automatic fetch(input logic [31:0] word);
        instr_ack   = 1'b1;
        instr_rdata = word;
        step();
        instr_ack   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h100); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL reset_ir got %h want %h", ir, 32'h0); end
        checks++; if (instr_req !== 1'b0) begin errors++; $display("FAIL reset_instr_req got %b want 0", instr_req); end
        checks++; if ({data_req, reg_write, halted, bus_error} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b want 0000", {data_req, reg_write, halted, bus_error}); end
        reset = 1'b0;
        #1;
        checks++; if (instr_req !== 1'b1) begin errors++; $display("FAIL release_instr_req got %b want 1", instr_req); end
        checks++; if (instr_addr !== 32'h100) begin errors++; $display("FAIL release_instr_addr got %h want %h", instr_addr, 32'h100); end
    endtask

    task automatic test_alu();
        fetch(32'h012A4020);
        checks++; if (ir !== 32'h012A4020) begin errors++; $display("FAIL add_ir got %h want %h", ir, 32'h012A4020); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL add_decode_rw got %b want 0", reg_write); end
        step();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL add_exec_rw got %b want 0", reg_write); end
        step();
        checks++; if (reg_write !== 1'b1 || mem_to_reg !== 2'b00) begin errors++; $display("FAIL add_wb got rw=%b m2r=%b want rw=1 m2r=00", reg_write, mem_to_reg); end
        step();
        checks++; if (pc !== 32'h104 || instr_req !== 1'b1) begin errors++; $display("FAIL add_done got pc=%h req=%b want pc=104 req=1", pc, instr_req); end
    endtask

    task automatic test_lw_wait();
        fetch(32'h8D090004);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (data_req !== 1'b1 || data_we !== 1'b0) begin errors++; $display("FAIL lw_mem%0d got req=%b we=%b want req=1 we=0", i, data_req, data_we); end
            if (i == 3) data_ack = 1'b1;
            step();
        end
        data_ack = 1'b0;
        checks++; if (reg_write !== 1'b1 || mem_to_reg !== 2'b01 || data_req !== 1'b0) begin errors++; $display("FAIL lw_wb got rw=%b m2r=%b req=%b want 1 01 0", reg_write, mem_to_reg, data_req); end
        step();
        checks++; if (pc !== 32'h108 || instr_req !== 1'b1) begin errors++; $display("FAIL lw_done got pc=%h req=%b want pc=108 req=1", pc, instr_req); end
    endtask

    task automatic test_beq();
        fetch(32'h08000008);
        step();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL j_pc got %h want %h", pc, 32'h20); end
        alu_zero = 1'b1;
        fetch(32'h1000FFFF);
        step();
        step();
        checks++; if (pc !== 32'h20 || instr_req !== 1'b1) begin errors++; $display("FAIL beq_taken got pc=%h req=%b want pc=20 req=1", pc, instr_req); end
        alu_zero = 1'b0;
        fetch(32'h1000FFFF);
        step();
        step();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL beq_not_taken got %h want %h", pc, 32'h24); end
    endtask

    task automatic test_jal();
        fetch(32'h08000002);
        step();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL j8_pc got %h want %h", pc, 32'h8); end
        fetch(32'h0C000010);
        checks++; if (reg_write !== 1'b1 || mem_to_reg !== 2'b10) begin errors++; $display("FAIL jal_link got rw=%b m2r=%b want rw=1 m2r=10", reg_write, mem_to_reg); end
        checks++; if (pc_plus4 !== 32'hC) begin errors++; $display("FAIL jal_pc_plus4 got %h want %h", pc_plus4, 32'hC); end
        step();
        checks++; if (pc !== 32'h40 || reg_write !== 1'b0) begin errors++; $display("FAIL jal_done got pc=%h rw=%b want pc=40 rw=0", pc, reg_write); end
    endtask

    task automatic test_sw_jr();
        fetch(32'hAD090000);
        step();
        step();
        checks++; if (data_req !== 1'b1 || data_we !== 1'b1) begin errors++; $display("FAIL sw_mem got req=%b we=%b want 1 1", data_req, data_we); end
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        checks++; if (pc !== 32'h44 || instr_req !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL sw_done got pc=%h req=%b rw=%b want 44 1 0", pc, instr_req, reg_write); end
        jr_target = 32'h200;
        fetch(32'h03E00008);
        step();
        step();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jr_pc got %h want %h", pc, 32'h200); end
    endtask

    task automatic test_ack_at_limit_then_halt();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) step();
        checks++; if (halted !== 1'b0 || instr_req !== 1'b1) begin errors++; $display("FAIL limit_wait got halted=%b req=%b want 0 1", halted, instr_req); end
        fetch(32'hFC000000);
        checks++; if (bus_error !== 1'b0 || ir !== 32'hFC000000) begin errors++; $display("FAIL limit_ack got err=%b ir=%h want 0 fc000000", bus_error, ir); end
        step();
        checks++; if (halted !== 1'b1 || bus_error !== 1'b0) begin errors++; $display("FAIL halt_op got halted=%b err=%b want 1 0", halted, bus_error); end
        instr_ack = 1'b1;
        data_ack  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (instr_req !== 1'b0 || data_req !== 1'b0 || halted !== 1'b1 || pc !== 32'h100) begin errors++; $display("FAIL halt_hold%0d got ireq=%b dreq=%b halted=%b pc=%h want 0 0 1 100", i, instr_req, data_req, halted, pc); end
        end
        instr_ack = 1'b0;
        data_ack  = 1'b0;
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        step();
        checks++; if (halted !== 1'b0 || bus_error !== 1'b0) begin errors++; $display("FAIL reset_clears_halt got halted=%b err=%b want 0 0", halted, bus_error); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) step();
        checks++; if (bus_error !== 1'b0 || instr_req !== 1'b1) begin errors++; $display("FAIL timeout_early got err=%b req=%b want 0 1", bus_error, instr_req); end
        step();
        checks++; if (bus_error !== 1'b1 || halted !== 1'b1 || instr_req !== 1'b0) begin errors++; $display("FAIL timeout got err=%b halted=%b req=%b want 1 1 0", bus_error, halted, instr_req); end
        step();
        checks++; if (bus_error !== 1'b1 || instr_req !== 1'b0) begin errors++; $display("FAIL timeout_sticky got err=%b req=%b want 1 0", bus_error, instr_req); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_beq();
        test_jal();
        test_sw_jr();
        test_ack_at_limit_then_halt();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
